reset_sequencer: RTL

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/xgcd_rst_pkg.sv | 25 ++
 rtl/rst_delay_counter.sv | 31 +++
 rtl/reset_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/xgcd_rst_pkg.sv
// Shared types and default constants for the staged reset sequencer.
package xgcd_rst_pkg;

   typedef enum logic [1:0] {
      ST_RELEASE = 2'b00,
      ST_RUN     = 2'b01,
      ST_HOLD    = 2'b10
   } seq_state_e;

   typedef enum logic [1:0] {
      CAUSE_POR  = 2'b00,
      CAUSE_SW   = 2'b01,
      CAUSE_WDOG = 2'b10
   } rst_cause_e;

   localparam int DEF_NSTAGE    = 4;
   localparam int DEF_STAGE_DLY = 16;
   localparam int DEF_HOLD_CYC  = 8;
   localparam int DEF_WDOG_TO   = 1000;

   // Widths sized for the largest legal STAGE_DLY/HOLD_CYC and WDOG_TO
   localparam int DLY_W  = 8;
   localparam int WDOG_W = 16;

endpackage

// File: rtl/rst_delay_counter.sv
// Up-counter with synchronous load and a terminal-count compare flag.
module rst_delay_counter #(
   parameter int W = 8
) (
   input  logic         CLK,
   input  logic         RESETn,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         enable,
   input  logic [W-1:0] term_val,
   output logic         tc
);

   logic [W-1:0] count_r;

   // Load takes priority over counting
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         count_r <= '0;
      end else if (load) begin
         count_r <= load_val;
      end else if (enable) begin
         count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign tc = (count_r == term_val);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release with software and watchdog reset sources.
module reset_sequencer
   import xgcd_rst_pkg::*;
#(
   parameter int NSTAGE    = DEF_NSTAGE,
   parameter int STAGE_DLY = DEF_STAGE_DLY,
   parameter int HOLD_CYC  = DEF_HOLD_CYC,
   parameter int WDOG_TO   = DEF_WDOG_TO
) (
   input  logic              CLK,
   input  logic              RESETn,
   input  logic              SW_RST_REQ,
   input  logic              WDOG_EN,
   input  logic              WDOG_KICK,
   output logic [NSTAGE-1:0] STAGE_RESETn,
   output logic              SEQ_DONE,
   output logic [1:0]        RST_CAUSE
);

   localparam logic [DLY_W-1:0]  STAGE_TERM = DLY_W'(STAGE_DLY - 1);
   localparam logic [DLY_W-1:0]  HOLD_TERM  = DLY_W'(HOLD_CYC - 1);
   localparam logic [WDOG_W-1:0] WDOG_TERM  = WDOG_W'(WDOG_TO - 1);
   localparam logic [NSTAGE-1:0] STAGE_ONE  = NSTAGE'(1'b1);

   seq_state_e        state_r;
   logic [NSTAGE-1:0] stage_r;
   logic              done_r;
   rst_cause_e        cause_r;

   logic              dly_load_s;
   logic              dly_en_s;
   logic              dly_tc_s;
   logic [DLY_W-1:0]  dly_term_s;
   logic              wd_load_s;
   logic              wd_tc_s;
   logic              sw_hit_s;
   logic              wd_fire_s;
   logic [NSTAGE-1:0] stage_next_s;

   // One counter times both stage spacing and the hold window; parked at 0 in RUN
   always_comb begin
      dly_load_s = 1'b0;
      dly_en_s   = 1'b0;
      dly_term_s = STAGE_TERM;
      case (state_r)
         ST_RELEASE: begin
            dly_en_s   = 1'b1;
            dly_load_s = dly_tc_s;
         end
         ST_HOLD: begin
            dly_en_s   = 1'b1;
            dly_term_s = HOLD_TERM;
            dly_load_s = dly_tc_s;
         end
         ST_RUN:  dly_load_s = 1'b1;
         default: dly_load_s = 1'b1;
      endcase
   end

   assign sw_hit_s     = (state_r == ST_RUN) && SW_RST_REQ;
   assign wd_fire_s    = (state_r == ST_RUN) && WDOG_EN && !WDOG_KICK && wd_tc_s;
   assign wd_load_s    = (state_r != ST_RUN) || !WDOG_EN || WDOG_KICK || SW_RST_REQ || wd_tc_s;
   assign stage_next_s = (stage_r << 1'b1) | STAGE_ONE;

   rst_delay_counter #(.W(DLY_W)) u_dly_cnt (
      .CLK      (CLK),
      .RESETn   (RESETn),
      .load     (dly_load_s),
      .load_val ({DLY_W{1'b0}}),
      .enable   (dly_en_s),
      .term_val (dly_term_s),
      .tc       (dly_tc_s)
   );

   rst_delay_counter #(.W(WDOG_W)) u_wdog_cnt (
      .CLK      (CLK),
      .RESETn   (RESETn),
      .load     (wd_load_s),
      .load_val ({WDOG_W{1'b0}}),
      .enable   (1'b1),
      .term_val (WDOG_TERM),
      .tc       (wd_tc_s)
   );

   // Sequencer FSM with registered stage, done and cause outputs
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_r <= ST_RELEASE;
         stage_r <= '0;
         done_r  <= 1'b0;
         cause_r <= CAUSE_POR;
      end else begin
         case (state_r)
            ST_RELEASE: begin
               if (dly_tc_s) begin
                  stage_r <= stage_next_s;
                  if (&stage_next_s) begin
                     done_r  <= 1'b1;
                     state_r <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               // Software request outranks a coincident watchdog timeout
               if (sw_hit_s) begin
                  stage_r <= '0;
                  done_r  <= 1'b0;
                  cause_r <= CAUSE_SW;
                  state_r <= ST_HOLD;
               end else if (wd_fire_s) begin
                  stage_r <= '0;
                  done_r  <= 1'b0;
                  cause_r <= CAUSE_WDOG;
                  state_r <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (dly_tc_s) begin
                  state_r <= ST_RELEASE;
               end
            end
            default: begin
               state_r <= ST_RELEASE;
               stage_r <= '0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign STAGE_RESETn = stage_r;
   assign SEQ_DONE     = done_r;
   assign RST_CAUSE    = cause_r;

endmodule
